fetch_sequencer: RTL

Instruction-fetch and sequence-driving front end for the basic-computer control path. Reads instructions from memory over a req/ack handshake, holds PC/AR/IR, and drives the encoded opcode, indirect bit and sequence-counter controls (`sc_inr`, `sc_clr`) that the timing-signal decoder and control gates consume. Hands each decoded instruction to the execute stage and waits for completion before fetching the next.

---
 rtl/fetch_sequencer_pkg.sv | 34 +++
 rtl/fetch_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_pkg
// Brief    : Shared types and constants for the instruction-fetch sequencer:
//            state encoding, IR field geometry and the register/IO opcode.
// Revision : 1.0  initial release
// ============================================================================
package fetch_sequencer_pkg;

    // Default address and memory-word widths
    localparam int c_AW_DEFAULT = 12;
    localparam int c_DW_DEFAULT = 16;

    // IR layout from the top: {I, opcode[2:0], addr}
    localparam int c_OPC_W      = 3;
    localparam int c_SC_W       = 4;

    // Opcode that marks register-reference / IO instructions (never indirect)
    localparam logic [c_OPC_W-1:0] c_OPC_REGIO = 3'b111;

    // Sequence counter ceiling; the counter saturates here instead of wrapping
    localparam logic [c_SC_W-1:0]  c_SC_MAX    = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_T0_ADDR   = 3'd1,
        S_T1_READ   = 3'd2,
        S_T2_DECODE = 3'd3,
        S_T3_IND    = 3'd4,
        S_EXEC      = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction fetch / decode front end. Reads instructions over a
//            req/ack port, resolves indirect addressing, drives opcode, I bit
//            and sequence-counter strobes, and hands off to the execute stage.
// Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = c_AW_DEFAULT,
    parameter int DW = c_DW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               mem_req,
    output logic [AW-1:0]      mem_addr,
    input  logic               mem_ack,
    input  logic [DW-1:0]      mem_rdata,
    input  logic               pc_load,
    input  logic [AW-1:0]      pc_din,
    output logic [c_OPC_W-1:0] opcode,
    output logic               ir_i,
    output logic [AW-1:0]      ar,
    output logic [AW-1:0]      pc,
    output logic [c_SC_W-1:0]  sc_count,
    output logic               sc_inr,
    output logic               sc_clr,
    output logic               exec_valid,
    input  logic               exec_done,
    output logic               busy
);

    // IR field positions derived from the word width
    localparam int c_I_BIT  = DW - 1;
    localparam int c_OPC_HI = DW - 2;
    localparam int c_OPC_LO = DW - 1 - c_OPC_W;

    localparam logic [AW-1:0] c_PC_ONE = 1;

    state_t              r_state;
    state_t              w_next;
    logic                w_advance;
    logic                w_clr;

    logic [AW-1:0]       r_pc;
    logic [AW-1:0]       r_ar;
    logic [DW-1:0]       r_ir;
    logic [c_OPC_W-1:0]  r_opcode;
    logic                r_ir_i;
    logic [c_SC_W-1:0]   r_sc_count;
    logic                r_sc_inr;
    logic                r_sc_clr;
    logic                r_exec_valid;
    logic                r_busy;

    logic [c_OPC_W-1:0]  w_ir_opc;
    logic                w_ir_ind;

    assign w_ir_opc = r_ir[c_OPC_HI:c_OPC_LO];
    // Register/IO instructions reuse the I bit, so they never go indirect
    assign w_ir_ind = r_ir[c_I_BIT] && (w_ir_opc != c_OPC_REGIO);

    // Next state; w_advance marks T-steps that bump the sequence counter
    always_comb begin
        w_next    = r_state;
        w_advance = 1'b0;
        w_clr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_T0_ADDR;
                end
            end
            S_T0_ADDR: begin
                w_next    = S_T1_READ;
                w_advance = 1'b1;
            end
            S_T1_READ: begin
                if (mem_ack) begin
                    w_next    = S_T2_DECODE;
                    w_advance = 1'b1;
                end
            end
            S_T2_DECODE: begin
                w_advance = 1'b1;
                w_next    = w_ir_ind ? S_T3_IND : S_EXEC;
            end
            S_T3_IND: begin
                if (mem_ack) begin
                    w_next    = S_EXEC;
                    w_advance = 1'b1;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    w_clr  = 1'b1;
                    w_next = run ? S_T0_ADDR : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register and sequence counter with registered strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_sc_count   <= '0;
            r_sc_inr     <= 1'b0;
            r_sc_clr     <= 1'b0;
            r_exec_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_sc_inr     <= w_advance;
            r_sc_clr     <= w_clr;
            r_exec_valid <= (w_next == S_EXEC);
            r_busy       <= (w_next != S_IDLE);
            if (w_clr) begin
                r_sc_count <= '0;
            end else if (w_advance && (r_sc_count != c_SC_MAX)) begin
                r_sc_count <= r_sc_count + 4'd1;
            end
        end
    end

    // PC/AR/IR datapath and decoded IR fields, updated per T-step
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc     <= '0;
            r_ar     <= '0;
            r_ir     <= '0;
            r_opcode <= '0;
            r_ir_i   <= 1'b0;
        end else begin
            case (r_state)
                S_T0_ADDR: begin
                    r_ar <= r_pc;
                end
                S_T1_READ: begin
                    if (mem_ack) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + c_PC_ONE;
                    end
                end
                S_T2_DECODE: begin
                    r_ar     <= r_ir[AW-1:0];
                    r_opcode <= w_ir_opc;
                    r_ir_i   <= r_ir[c_I_BIT];
                end
                S_T3_IND: begin
                    if (mem_ack) begin
                        r_ar <= mem_rdata[AW-1:0];
                    end
                end
                S_EXEC: begin
                    if (exec_done && pc_load) begin
                        r_pc <= pc_din;
                    end
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    // Memory port is decoded straight from state so it drops the cycle after ack
    assign mem_req    = (r_state == S_T1_READ) || (r_state == S_T3_IND);
    assign mem_addr   = r_ar;

    assign opcode     = r_opcode;
    assign ir_i       = r_ir_i;
    assign ar         = r_ar;
    assign pc         = r_pc;
    assign sc_count   = r_sc_count;
    assign sc_inr     = r_sc_inr;
    assign sc_clr     = r_sc_clr;
    assign exec_valid = r_exec_valid;
    assign busy       = r_busy;

endmodule
`default_nettype wire
